// File: rtl/alu.sv
// 32-bit integer ALU: combinational datapath selected by a 4-bit opcode,
// with the result and its zero flag registered together (one-cycle latency).
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALUSrcA,
    input  logic [WIDTH-1:0] ALUSrcB,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] ALUResult,
    output logic             ALUZero
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    logic [WIDTH-1:0] res_d, res_q;
    logic             zero_d, zero_q;
    logic [4:0]       shamt;
    logic             lt_s, lt_u;

    // Shift amount comes only from the low five bits; upper bits of B are ignored.
    assign shamt = ALUSrcB[4:0];
    assign lt_s  = $signed(ALUSrcA) < $signed(ALUSrcB);
    assign lt_u  = ALUSrcA < ALUSrcB;

    always_comb begin
        res_d = '0;
        unique case (ALUOp)
            OP_ADD:  res_d = ALUSrcA + ALUSrcB;
            OP_SUB:  res_d = ALUSrcA - ALUSrcB;
            OP_AND:  res_d = ALUSrcA & ALUSrcB;
            OP_OR:   res_d = ALUSrcA | ALUSrcB;
            OP_SLL:  res_d = ALUSrcA << shamt;
            OP_SRL:  res_d = ALUSrcA >> shamt;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SRA:  res_d = unsigned'($signed(ALUSrcA) >>> shamt);
            OP_XOR:  res_d = ALUSrcA ^ ALUSrcB;
            OP_NOR:  res_d = ~(ALUSrcA | ALUSrcB);
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, lt_u};
            OP_LUI:  res_d = {ALUSrcB[15:0], {(WIDTH-16){1'b0}}};
            default: res_d = '0;
        endcase
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            res_q  <= res_d;
            zero_q <= zero_d;
        end
    end

    assign ALUResult = res_q;
    assign ALUZero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU: each task drives its own
// vectors and compares result and zero flag one edge later.
module tb_alu;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] ALUSrcA, ALUSrcB;
    logic [3:0]  ALUOp;
    logic [31:0] ALUResult;
    logic        ALUZero;

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ALUResult (ALUResult),
        .ALUZero   (ALUZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation, let one rising edge capture it, then settle.
    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUOp   = op;
        ALUSrcA = a;
        ALUSrcB = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(4'd0, 32'd20, 32'd40);
        checks++;
        if (ALUResult !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected %h", ALUResult, 32'h0);
        end
        checks++;
        if (ALUZero !== 1'b1) begin
            errors++;
            $display("FAIL reset_zero: got %b expected 1", ALUZero);
        end
        reset = 1'b0;
        apply(4'd0, 32'd20, 32'd40);
        checks++;
        if (ALUResult !== 32'd60) begin
            errors++;
            $display("FAIL first_after_reset: got %h expected %h", ALUResult, 32'd60);
        end
        checks++;
        if (ALUZero !== 1'b0) begin
            errors++;
            $display("FAIL first_after_reset_zero: got %b expected 0", ALUZero);
        end
    endtask

    task automatic test_arith_logic();
        vec_t v[9];
        v[0] = '{4'd0, 32'd20,         32'd40,         32'd60};
        v[1] = '{4'd1, 32'd20,         32'd40,         32'hFFFF_FFEC};
        v[2] = '{4'd0, 32'hFFFF_FFFF,  32'd1,          32'h0};
        v[3] = '{4'd1, 32'd5,          32'd5,          32'h0};
        v[4] = '{4'd2, 32'd1,          32'd2,          32'h0};
        v[5] = '{4'd3, 32'd1,          32'd2,          32'h3};
        v[6] = '{4'd8, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'hF00F_F00F};
        v[7] = '{4'd9, 32'h0,          32'h0,          32'hFFFF_FFFF};
        v[8] = '{4'd9, 32'hFFFF_0000,  32'h0000_FFFF,  32'h0};
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b);
            checks++;
            if (ALUResult !== v[i].exp) begin
                errors++;
                $display("FAIL arith_logic[%0d] result: got %h expected %h", i, ALUResult, v[i].exp);
            end
            checks++;
            if (ALUZero !== (v[i].exp == 32'h0)) begin
                errors++;
                $display("FAIL arith_logic[%0d] zero: got %b expected %b", i, ALUZero, v[i].exp == 32'h0);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[8];
        v[0] = '{4'd4, 32'h0000_FF00, 32'd8,          32'h00FF_0000};
        v[1] = '{4'd5, 32'hF000_FF00, 32'd8,          32'h00F0_00FF};
        v[2] = '{4'd7, 32'hF000_FF00, 32'd8,          32'hFFF0_00FF};
        v[3] = '{4'd4, 32'h0000_FF00, 32'h0000_0028,  32'h00FF_0000};
        v[4] = '{4'd7, 32'h8000_0000, 32'h0,          32'h8000_0000};
        v[5] = '{4'd7, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF};
        v[6] = '{4'd5, 32'h8000_0000, 32'd31,         32'h0000_0001};
        v[7] = '{4'd4, 32'h0000_0001, 32'hFFFF_FFFF,  32'h8000_0000};
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b);
            checks++;
            if (ALUResult !== v[i].exp) begin
                errors++;
                $display("FAIL shift[%0d] result: got %h expected %h", i, ALUResult, v[i].exp);
            end
        end
    endtask

    task automatic test_compare();
        vec_t v[6];
        v[0] = '{4'd6,  32'h0000_FF00, 32'h0000_FFFF, 32'd1};
        v[1] = '{4'd6,  32'h0000_FF00, 32'hF000_FFFF, 32'd0};
        v[2] = '{4'd10, 32'h0000_FF00, 32'hF000_FFFF, 32'd1};
        v[3] = '{4'd6,  32'hFFFF_FFFF, 32'h0,         32'd1};
        v[4] = '{4'd10, 32'hFFFF_FFFF, 32'h0,         32'd0};
        v[5] = '{4'd10, 32'd7,         32'd7,         32'd0};
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b);
            checks++;
            if (ALUResult !== v[i].exp) begin
                errors++;
                $display("FAIL compare[%0d] result: got %h expected %h", i, ALUResult, v[i].exp);
            end
            checks++;
            if (ALUZero !== (v[i].exp == 32'h0)) begin
                errors++;
                $display("FAIL compare[%0d] zero: got %b expected %b", i, ALUZero, v[i].exp == 32'h0);
            end
        end
    endtask

    task automatic test_lui_reserved();
        vec_t v[5];
        v[0] = '{4'd11, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000};
        v[1] = '{4'd13, 32'd20,        32'd40,        32'h0};
        v[2] = '{4'd11, 32'h0,         32'hABCD_8001, 32'h8001_0000};
        v[3] = '{4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        v[4] = '{4'd15, 32'h1234_5678, 32'h1,         32'h0};
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b);
            checks++;
            if (ALUResult !== v[i].exp) begin
                errors++;
                $display("FAIL lui_reserved[%0d] result: got %h expected %h", i, ALUResult, v[i].exp);
            end
            checks++;
            if (ALUZero !== (v[i].exp == 32'h0)) begin
                errors++;
                $display("FAIL lui_reserved[%0d] zero: got %b expected %b", i, ALUZero, v[i].exp == 32'h0);
            end
        end
    endtask

    // Every cycle a new op; each result must belong to the op of the previous edge.
    task automatic test_back_to_back();
        vec_t v[4];
        v[0] = '{4'd0, 32'd1,         32'd2,  32'd3};
        v[1] = '{4'd1, 32'd3,         32'd3,  32'd0};
        v[2] = '{4'd3, 32'hF0,        32'h0F, 32'hFF};
        v[3] = '{4'd5, 32'h8000_0000, 32'd4,  32'h0800_0000};
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b);
            checks++;
            if (ALUResult !== v[i].exp || ALUZero !== (v[i].exp == 32'h0)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h/%b expected %h/%b",
                         i, ALUResult, ALUZero, v[i].exp, v[i].exp == 32'h0);
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply(4'd0, 32'd20, 32'd40);
        reset = 1'b1;
        apply(4'd1, 32'd20, 32'd40);
        checks++;
        if (ALUResult !== 32'h0 || ALUZero !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got %h/%b expected 00000000/1", ALUResult, ALUZero);
        end
        reset = 1'b0;
        apply(4'd3, 32'd1, 32'd2);
        checks++;
        if (ALUResult !== 32'h3 || ALUZero !== 1'b0) begin
            errors++;
            $display("FAIL after_mid_reset: got %h/%b expected 00000003/0", ALUResult, ALUZero);
        end
    endtask

    initial begin
        reset   = 1'b1;
        ALUOp   = 4'd0;
        ALUSrcA = 32'h0;
        ALUSrcB = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_arith_logic();
        test_shift();
        test_compare();
        test_lui_reserved();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
